// File: rtl/compressor_if.sv
// compressor_if: stream bundle for the beat compressor.
//   master modport : upstream/downstream driver side (bench or parent)
//   slave modport  : compressor side
//   wrt_en      compression enable, sampled on a packet's first beat
//   data_in     input beat, byte k = data_in[8k+7:8k]
//   tvalid_in   input beat valid
//   tlast_in    last beat of input packet
//   tready_in   downstream ready; also gates upstream acceptance
//   data_out    output beat (literal or run token)
//   tvalid_out  output beat valid
//   tlast_out   last beat of output packet
//   tkeep       byte mask: all-ones = literal, 0000_000F = run token
interface compressor_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DATA   = 32
);
    logic                            wrt_en;
    logic [DATA_WIDTH*NUM_DATA-1:0]  data_in;
    logic                            tvalid_in;
    logic                            tlast_in;
    logic                            tready_in;
    logic [DATA_WIDTH*NUM_DATA-1:0]  data_out;
    logic                            tvalid_out;
    logic                            tlast_out;
    logic [NUM_DATA-1:0]             tkeep;

    modport master (
        output wrt_en, data_in, tvalid_in, tlast_in, tready_in,
        input  data_out, tvalid_out, tlast_out, tkeep
    );

    modport slave (
        input  wrt_en, data_in, tvalid_in, tlast_in, tready_in,
        output data_out, tvalid_out, tlast_out, tkeep
    );
endinterface

// File: rtl/compressor.sv
// compressor: AXI-Stream beat compressor on the 256-bit packet path.
// The first beat of each packet is inspected; IPv4/TCP packets with
// compression enabled have runs of identical payload beats replaced by a
// literal beat followed by a 4-byte run token holding the repeat count.
// Everything else passes through as literals.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    compressor_if.slave stream bundle
//
// state | meaning
// HDR   | waiting for / consuming the first beat of a packet
// PASS  | non-compressible packet, copy beats as literals
// RUN   | compressible packet, run-length encode payload beats
module compressor #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DATA   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    compressor_if.slave  bus
);
    localparam int BUS_W = DATA_WIDTH * NUM_DATA;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [BUS_W-1:0]    data;
        logic [NUM_DATA-1:0] keep;
        logic                last;
    } entry_t;

    typedef enum logic [1:0] {HDR, PASS, RUN} state_t;

    state_t             state, state_nxt;
    logic [BUS_W-1:0]   hold, hold_nxt;
    logic               hold_v, hold_v_nxt;
    logic [31:0]        run_cnt, run_cnt_nxt;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   fifo_cnt;

    logic               accept;
    logic               pop;
    logic               compressible;
    logic [1:0]         n_push;
    entry_t             ent0, ent1;
    entry_t             head;

    function automatic entry_t make_lit(input logic [BUS_W-1:0] d, input logic l);
        entry_t e;
        e.data = d;
        e.keep = '1;
        e.last = l;
        return e;
    endfunction

    function automatic entry_t make_tok(input logic [31:0] c, input logic l);
        entry_t e;
        e.data = BUS_W'(c);
        e.keep = NUM_DATA'(4'hF);
        e.last = l;
        return e;
    endfunction

    assign accept = bus.tvalid_in && bus.tready_in;
    assign pop    = (fifo_cnt != '0) && bus.tready_in;

    assign compressible = bus.wrt_en
        && (bus.data_in[12*DATA_WIDTH +: DATA_WIDTH] == DATA_WIDTH'(8'h08))
        && (bus.data_in[13*DATA_WIDTH +: DATA_WIDTH] == DATA_WIDTH'(8'h00))
        && (bus.data_in[23*DATA_WIDTH +: DATA_WIDTH] == DATA_WIDTH'(8'h06));

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold;
        hold_v_nxt  = hold_v;
        run_cnt_nxt = run_cnt;
        n_push      = 2'd0;
        ent0        = '0;
        ent1        = '0;
        if (accept) begin
            case (state)
                HDR: begin
                    ent0   = make_lit(bus.data_in, bus.tlast_in);
                    n_push = 2'd1;
                    if (!bus.tlast_in)
                        state_nxt = compressible ? RUN : PASS;
                end
                PASS: begin
                    ent0   = make_lit(bus.data_in, bus.tlast_in);
                    n_push = 2'd1;
                    if (bus.tlast_in)
                        state_nxt = HDR;
                end
                RUN: begin
                    if (!hold_v) begin
                        ent0        = make_lit(bus.data_in, bus.tlast_in);
                        n_push      = 2'd1;
                        hold_nxt    = bus.data_in;
                        hold_v_nxt  = 1'b1;
                        run_cnt_nxt = '0;
                    end else if (bus.data_in == hold) begin
                        // A count that would hit all-ones is flushed at once so
                        // the token field never wraps; the held beat stays.
                        if (run_cnt == 32'hFFFF_FFFE) begin
                            ent0        = make_tok(32'hFFFF_FFFF, bus.tlast_in);
                            n_push      = 2'd1;
                            run_cnt_nxt = '0;
                        end else begin
                            run_cnt_nxt = run_cnt + 32'd1;
                            if (bus.tlast_in) begin
                                ent0   = make_tok(run_cnt + 32'd1, 1'b1);
                                n_push = 2'd1;
                            end
                        end
                    end else begin
                        if (run_cnt != '0) begin
                            ent0   = make_tok(run_cnt, 1'b0);
                            ent1   = make_lit(bus.data_in, bus.tlast_in);
                            n_push = 2'd2;
                        end else begin
                            ent0   = make_lit(bus.data_in, bus.tlast_in);
                            n_push = 2'd1;
                        end
                        hold_nxt    = bus.data_in;
                        run_cnt_nxt = '0;
                    end
                    if (bus.tlast_in) begin
                        hold_v_nxt  = 1'b0;
                        hold_nxt    = '0;
                        run_cnt_nxt = '0;
                        state_nxt   = HDR;
                    end
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= HDR;
            hold    <= '0;
            hold_v  <= 1'b0;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            hold    <= hold_nxt;
            hold_v  <= hold_v_nxt;
            run_cnt <= run_cnt_nxt;
        end
    end

    // Output queue. Pop and push positions are independent, so pop-first
    // ordering only matters for the occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (n_push != 2'd0)
                mem[wr_ptr] <= ent0;
            if (n_push == 2'd2)
                mem[wr_ptr + PTR_W'(1)] <= ent1;
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr   <= wr_ptr + PTR_W'(n_push);
            fifo_cnt <= fifo_cnt - CNT_W'(pop) + CNT_W'(n_push);
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.tvalid_out = (fifo_cnt != '0);
    assign bus.data_out   = bus.tvalid_out ? head.data : '0;
    assign bus.tkeep      = bus.tvalid_out ? head.keep : '0;
    assign bus.tlast_out  = bus.tvalid_out ? head.last : 1'b0;

endmodule

// File: tb/tb_compressor.sv
// tb_compressor: self-checking bench for compressor. A packet-level
// reference queue predicts the output stream; outputs are compared to its
// head on every falling edge, and directed packets are pinned with literals.
module tb_compressor;
    localparam int BW = 256;

    typedef struct packed {
        logic [BW-1:0] d;
        logic [31:0]   k;
        logic          l;
    } ent_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    compressor_if bus ();

    compressor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t exp_q[$];
    ent_t obs_q[$];

    task automatic chk(input string name, input logic [289:0] act, input logic [289:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic ent_t lit(input logic [BW-1:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.k = 32'hFFFF_FFFF;
        e.l = l;
        return e;
    endfunction

    function automatic ent_t tok(input logic [31:0] c, input logic l);
        ent_t e;
        e.d = {224'd0, c};
        e.k = 32'h0000_000F;
        e.l = l;
        return e;
    endfunction

    // Reference: packet mode, last payload beat seen, extra repeats so far.
    int            m_mode;   // 0 = at packet start, 1 = copy, 2 = encode
    logic [BW-1:0] m_prev;
    bit            m_have_prev;
    logic [31:0]   m_rep;

    function automatic bit is_tcp(input logic [BW-1:0] d, input logic en);
        return en && d[96 +: 8] == 8'h08 && d[104 +: 8] == 8'h00 && d[184 +: 8] == 8'h06;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_mode      = 0;
            m_have_prev = 0;
            m_rep       = 0;
        end else begin
            if (exp_q.size() > 0 && bus.tready_in)
                void'(exp_q.pop_front());
            if (bus.tvalid_in && bus.tready_in) begin
                logic [BW-1:0] b;
                logic          t;
                b = bus.data_in;
                t = bus.tlast_in;
                if (m_mode == 0) begin
                    exp_q.push_back(lit(b, t));
                    if (!t) m_mode = is_tcp(b, bus.wrt_en) ? 2 : 1;
                end else if (m_mode == 1) begin
                    exp_q.push_back(lit(b, t));
                    if (t) m_mode = 0;
                end else begin
                    if (m_have_prev && b == m_prev) begin
                        m_rep = m_rep + 1;
                        if (m_rep == 32'hFFFF_FFFF) begin
                            exp_q.push_back(tok(m_rep, t));
                            m_rep = 0;
                        end else if (t) begin
                            exp_q.push_back(tok(m_rep, 1'b1));
                        end
                    end else begin
                        if (m_rep > 0) exp_q.push_back(tok(m_rep, 1'b0));
                        exp_q.push_back(lit(b, t));
                        m_prev      = b;
                        m_have_prev = 1;
                        m_rep       = 0;
                    end
                    if (t) begin
                        m_mode      = 0;
                        m_have_prev = 0;
                        m_rep       = 0;
                    end
                end
                if (exp_q.size() > 4) begin
                    total++;
                    bad++;
                    $display("FAIL overflow occupancy=%0d limit=4", exp_q.size());
                end
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)
            obs_q.delete();
        else if (bus.tvalid_out && bus.tready_in)
            obs_q.push_back({bus.data_out, bus.tkeep, bus.tlast_out});
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            ent_t e;
            logic v;
            v = exp_q.size() > 0;
            e = v ? exp_q[0] : '0;
            chk("cycle_out", {bus.tvalid_out, bus.data_out, bus.tkeep, bus.tlast_out}, {v, e});
        end
    end

    logic [BW-1:0] hdr, pat_p, pat_q, pat_x, ones;
    bit            rnd_ready = 0;

    task automatic send(input logic [BW-1:0] d, input logic l, input int stall);
        bit acc;
        bus.data_in   = d;
        bus.tlast_in  = l;
        bus.tvalid_in = 1'b1;
        for (int n = 0; n < stall; n++) begin
            bus.tready_in = 1'b0;
            @(posedge clk); #1;
        end
        do begin
            bus.tready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            acc = bus.tready_in;
            @(posedge clk); #1;
        end while (!acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.tvalid_in = 1'b0;
        bus.tready_in = 1'b1;
        while ((exp_q.size() != 0 || bus.tvalid_out) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", 290'(n >= 50), 290'(0));
    endtask

    function automatic logic [BW-1:0] rnd_beat();
        logic [BW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        ent_t exp_list[$];

        ones  = '1;
        hdr   = '0;
        hdr[96 +: 8]  = 8'h08;
        hdr[104 +: 8] = 8'h00;
        hdr[112 +: 8] = 8'h45;
        hdr[120 +: 8] = 8'h28;
        hdr[128 +: 8] = 8'h03;
        hdr[136 +: 8] = 8'hDC;
        hdr[184 +: 8] = 8'h06;
        pat_p = {8{32'hBA98_FEDC}};
        pat_q = {8{32'hFEDC_BA98}};
        pat_x = {32'h22EC_4084, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0F1E_2D3C_4B5A_6978, 32'h0000_3B95};

        bus.wrt_en    = 1'b1;
        bus.data_in   = '0;
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        bus.tready_in = 1'b1;
        reset         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.tvalid_out, bus.data_out, bus.tkeep, bus.tlast_out}, '0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_output", 290'(bus.tvalid_out), 290'(0));

        // Non-matching packet passes through untouched.
        obs_q.delete();
        for (int i = 0; i < 3; i++) send(ones, 1'b0, 0);
        send(pat_x, 1'b1, 0);
        drain();
        chk("pass_count", 290'(obs_q.size()), 290'(4));
        exp_list = '{lit(ones, 0), lit(ones, 0), lit(ones, 0), lit(pat_x, 1)};
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            chk($sformatf("pass_beat%0d", i), 290'(obs_q[i]), 290'(exp_list[i]));

        // Compressible packet: five P collapse to P + token(4).
        obs_q.delete();
        send(hdr, 1'b0, 0);
        for (int i = 0; i < 5; i++) send(pat_p, 1'b0, 0);
        send(pat_q, 1'b1, 0);
        drain();
        exp_list = '{lit(hdr, 0), lit(pat_p, 0), tok(32'd4, 0), lit(pat_q, 1)};
        chk("comp_count", 290'(obs_q.size()), 290'(4));
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            chk($sformatf("comp_beat%0d", i), 290'(obs_q[i]), 290'(exp_list[i]));

        // Same packet with compression disabled.
        obs_q.delete();
        bus.wrt_en = 1'b0;
        send(hdr, 1'b0, 0);
        for (int i = 0; i < 5; i++) send(pat_p, 1'b0, 0);
        send(pat_q, 1'b1, 0);
        drain();
        bus.wrt_en = 1'b1;
        chk("nocomp_count", 290'(obs_q.size()), 290'(7));
        for (int i = 0; i < 7 && i < obs_q.size(); i++)
            chk($sformatf("nocomp_beat%0d", i), 290'(obs_q[i]),
                290'(lit(i == 0 ? hdr : (i == 6 ? pat_q : pat_p), i == 6)));

        // Packet ending on a repeat, then a single-beat packet.
        obs_q.delete();
        send(hdr, 1'b0, 0);
        send(pat_p, 1'b0, 0);
        send(pat_p, 1'b1, 0);
        send(pat_p, 1'b1, 0);
        drain();
        exp_list = '{lit(hdr, 0), lit(pat_p, 0), tok(32'd1, 1), lit(pat_p, 1)};
        chk("rep_end_count", 290'(obs_q.size()), 290'(4));
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            chk($sformatf("rep_end_beat%0d", i), 290'(obs_q[i]), 290'(exp_list[i]));

        // Three-cycle stall in the middle of a compressible stream.
        obs_q.delete();
        send(hdr, 1'b0, 0);
        send(pat_p, 1'b0, 0);
        send(pat_p, 1'b0, 3);
        for (int i = 0; i < 3; i++) send(pat_p, 1'b0, 0);
        send(pat_q, 1'b1, 0);
        drain();
        exp_list = '{lit(hdr, 0), lit(pat_p, 0), tok(32'd4, 0), lit(pat_q, 1)};
        chk("stall_count", 290'(obs_q.size()), 290'(4));
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            chk($sformatf("stall_beat%0d", i), 290'(obs_q[i]), 290'(exp_list[i]));

        // Reset in the middle of a packet discards everything in flight.
        send(hdr, 1'b0, 0);
        send(pat_p, 1'b0, 0);
        send(pat_p, 1'b0, 0);
        bus.tvalid_in = 1'b0;
        bus.tready_in = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midreset_outputs", {bus.tvalid_out, bus.data_out, bus.tkeep, bus.tlast_out}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        obs_q.delete();
        send(pat_p, 1'b1, 0);
        drain();
        chk("midreset_count", 290'(obs_q.size()), 290'(1));
        if (obs_q.size() > 0)
            chk("midreset_hdr", 290'(obs_q[0]), 290'(lit(pat_p, 1)));

        // Randomized packets with random stalls and idle gaps.
        rnd_ready = 1;
        for (int p = 0; p < 150; p++) begin
            int            len;
            logic [BW-1:0] b, last_b;
            bus.wrt_en = $urandom_range(0, 3) != 0;
            len = $urandom_range(1, 10);
            b = ($urandom_range(0, 1) != 0) ? hdr : rnd_beat();
            b[112 +: 8] = 8'($urandom());
            last_b = pat_p;
            for (int i = 0; i < len; i++) begin
                if (i > 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r < 5)      b = last_b;
                    else if (r < 7) b = pat_p;
                    else if (r < 9) b = pat_q;
                    else            b = rnd_beat();
                    last_b = b;
                end
                send(b, i == len - 1, 0);
                if ($urandom_range(0, 7) == 0) bus.wrt_en = ~bus.wrt_en;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.tvalid_in = 1'b0;
                bus.tready_in = $urandom_range(0, 1) != 0;
                @(posedge clk); #1;
            end
        end
        rnd_ready = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/compressor.md
Name: compressor

Overview:
- AXI-Stream beat compressor sitting on the 256-bit packet datapath.
- Inspects the first beat of every packet. For IPv4/TCP packets with compression enabled, it run-length encodes consecutive identical payload beats into literal beats plus 4-byte run tokens.
- All other packets pass through unchanged.
- Output framing uses tkeep: all-ones marks a literal beat; 32'h0000_000F marks a run token.

Parameters:
- DATA_WIDTH, 8, bits per byte lane.
- NUM_DATA, 32, byte lanes per beat (bus width = DATA_WIDTH*NUM_DATA = 256).
- FIFO_DEPTH, 4, output queue entries.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wrt_en  input  1  compression enable, sampled on each packet's first beat.
- data_in  input  256  input beat; byte k = data_in[8k+7:8k].
- tvalid_in  input  1  input beat valid.
- tlast_in  input  1  last beat of input packet.
- tready_in  input  1  downstream ready; the same signal gates upstream.
- data_out  output  256  output beat.
- tvalid_out  output  1  output beat valid.
- tlast_out  output  1  last beat of output packet.
- tkeep  output  32  byte-valid mask of data_out.

Behaviour:
- Reset (asynchronous assertion, low):
  - FIFO emptied; state = HDR.
  - Run count = 0; held beat cleared.
  - data_out, tkeep, tvalid_out, tlast_out all 0.
  - Reset mid-packet discards all in-flight data.
- Acceptance: a beat is consumed on a rising edge with tvalid_in && tready_in. The upstream stalls on tready_in, so there is no separate upstream ready.
- Output:
  - FIFO head drives data_out/tkeep/tlast_out; tvalid_out = FIFO not empty.
  - Head pops on an edge with tvalid_out && tready_in.
  - Outputs are 0 when the FIFO is empty.
  - Outputs hold stable while tready_in = 0.
- Latency: 1 cycle. A beat pushed at edge t appears on outputs after edge t when the FIFO was empty.
- Pushes: each accepted beat pushes 0, 1 or 2 entries. With simultaneous pop and push, the pop is applied first.
- Overflow: depth 4 is sufficient; overflow is illegal (assertion in bench).
- State HDR (first beat of a packet):
  - Beat pushed as literal (tkeep = FFFF_FFFF).
  - Compressible iff wrt_en = 1 && byte12 = 8'h08 && byte13 = 8'h00 && byte23 = 8'h06.
  - tlast_in = 1: literal carries tlast_out, stay in HDR.
  - Otherwise go to RUN if compressible, else PASS.
- State PASS: every beat pushed as a literal, tlast copied. tlast → HDR.
- State RUN: held beat H (invalid initially), extra-repeat count C (32-bit).
  - H invalid: push literal B; H = B, C = 0.
  - B == H: C++; nothing pushed.
  - B != H: if C > 0, push token; then push literal B; H = B, C = 0.
  - Token format: data_out[31:0] = C, upper bits 0, tkeep = 32'h0000_000F.
  - C reaching 32'hFFFF_FFFF: push token immediately, C = 0, H retained.
- Packet end in RUN (tlast_in beat, after applying the rules above):
  - The final pushed entry carries tlast_out.
  - If B == H and C > 0 after increment, push the token with tlast_out.
  - Then clear H and return to HDR.
- wrt_en changes only take effect at the next packet's HDR beat.

Test Plan:
- Reset low for 2 cycles, then release → tvalid_out = 0, data_out = 0, tkeep = 0; no output until the first accepted beat.
- Non-matching packet, tready_in = 1: beats FF..FF ×3, then 22EC4084…3B95 with tlast → four identical literals out, tkeep = FFFF_FFFF, tlast_out only on the 4th, each 1 cycle after input.
- Compressible packet:
  - Input: header (byte12 = 08, byte13 = 00, byte23 = 06, byte15 = 28, bytes16–17 = 03 DC), then BA98FEDC-pattern beat P ×5, then FEDCBA98-pattern Q with tlast.
  - Output: header, P, token (data[31:0] = 4, tkeep = 0000_000F), Q with tlast_out.
- Same packet with wrt_en = 0 → 7 literals identical to input, tlast on the last.
- Repeat ending the packet: header, P, P (tlast) → header, P, token count 1 with tlast_out = 1. The next beat is again treated as a header.
- tready_in = 0 for 3 cycles mid-compressible stream (upstream stalled) → outputs frozen; after release the sequence is identical to the unstalled run, with no loss or duplication.
